// File: rtl/btn_pkg.sv
// Shared constants, sizing helpers and the event record for the button front end.
package btn_pkg;

  // Widest button index an event record can carry.
  localparam int EVT_ID_W = 8;

  // clog2 that never returns 0, so a 1-entry thing still gets a 1-bit field.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clock cycles per debounce sample.
  function automatic int tick_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

  // Sample ticks a button must stay down to count as a long press.
  function automatic int long_ticks(input int long_ms, input int sample_hz);
    return (long_ms * sample_hz) / 1000;
  endfunction

  typedef struct packed {
    logic [EVT_ID_W-1:0] id;
    logic                is_long;
  } evt_t;

endpackage

// File: rtl/btn_channel.sv
// One button: synchronizer, tick-sampled debounce and short/long press classifier.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEB_SAMPLES = 8,
  parameter int LONG_TICKS  = 1000
) (
  input  logic clk_100Mhz,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic short_evt_o,
  output logic long_evt_o
);

  localparam int DW = safe_clog2(DEB_SAMPLES);
  localparam int HW = safe_clog2(LONG_TICKS + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_SAMPLES - 1);
  localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);

  logic [1:0]    sync_q;
  logic [DW-1:0] deb_q, deb_d;
  logic          level_q, level_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          done_q, done_d;
  logic          short_q, short_d;
  logic          long_q, long_d;

  // Debounce counts consecutive differing samples; the hold counter times the
  // press and fires the long event once, a release before that fires short.
  always_comb begin
    deb_d   = deb_q;
    level_d = level_q;
    hold_d  = hold_q;
    done_d  = done_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    if (tick_i) begin
      if (sync_q[1] == level_q) begin
        deb_d = '0;
      end else if (deb_q == DEB_LAST) begin
        deb_d   = '0;
        level_d = ~level_q;
        if (!level_q) begin
          hold_d = '0;
          done_d = 1'b0;
        end else if (!done_q) begin
          short_d = 1'b1;
        end
      end else begin
        deb_d = deb_q + DW'(1);
      end
      // Only time the press on ticks where the button stays down.
      if (level_q && level_d && hold_q != LONG_MAX) begin
        hold_d = hold_q + HW'(1);
        if (hold_q == LONG_LAST && !done_q) begin
          long_d = 1'b1;
          done_d = 1'b1;
        end
      end
    end
  end

  // State registers; the synchronizer runs every clock, the rest advances on tick.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      deb_q   <= '0;
      level_q <= 1'b0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      deb_q   <= deb_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign level_o     = level_q;
  assign short_evt_o = short_q;
  assign long_evt_o  = long_q;

endmodule

// File: rtl/btn_event_arbiter.sv
// Button front end: shared sample tick, per-button channels, one pending-event
// slot per button and a round-robin valid/ready output register.
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN       = 5,
  parameter int CLK_HZ      = 100_000_000,
  parameter int SAMPLE_HZ   = 1_000,
  parameter int DEB_SAMPLES = 8,
  parameter int LONG_MS     = 1000,
  localparam int ID_W       = safe_clog2(N_BTN)
) (
  input  logic             clk_100Mhz,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_long,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] ovf,
  input  logic             ovf_clr
);

  localparam int TICK_DIV   = tick_div(CLK_HZ, SAMPLE_HZ);
  localparam int LONG_TICKS = long_ticks(LONG_MS, SAMPLE_HZ);
  localparam int TW         = safe_clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [ID_W-1:0] ID_LAST   = ID_W'(N_BTN - 1);

  logic [TW-1:0]    tick_cnt_q;
  logic             tick;
  logic [N_BTN-1:0] short_evt, long_evt;
  logic [N_BTN-1:0] slot_v_q, slot_v_d, slot_l_q, slot_l_d;
  logic [N_BTN-1:0] ovf_q, ovf_d;
  logic [ID_W-1:0]  ptr_q, ptr_d, sel;
  logic             found, load;
  logic             out_v_q, out_v_d;
  evt_t             out_q, out_d;
  int               idx;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Free-running sample-rate divider; one-cycle enable, not a derived clock.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEB_SAMPLES (DEB_SAMPLES),
      .LONG_TICKS  (LONG_TICKS)
    ) u_ch (
      .clk_100Mhz  (clk_100Mhz),
      .rst         (rst),
      .tick_i      (tick),
      .btn_i       (btn[i]),
      .level_o     (btn_level[i]),
      .short_evt_o (short_evt[i]),
      .long_evt_o  (long_evt[i])
    );
  end

  // Round-robin pick: first valid slot at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!found && slot_v_q[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  // Output load, slot clear/fill and overflow. The slot is cleared before new
  // events are considered, so an event arriving as its slot drains is kept.
  always_comb begin
    load     = !out_v_q || evt_ready;
    slot_v_d = slot_v_q;
    slot_l_d = slot_l_q;
    ovf_d    = ovf_clr ? '0 : ovf_q;
    out_v_d  = out_v_q;
    out_d    = out_q;
    ptr_d    = ptr_q;
    if (load) begin
      out_v_d = found;
      if (found) begin
        out_d.id      = EVT_ID_W'(sel);
        out_d.is_long = slot_l_q[sel];
        slot_v_d[sel] = 1'b0;
        ptr_d         = (sel == ID_LAST) ? '0 : sel + ID_W'(1);
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (short_evt[i] || long_evt[i]) begin
        if (!slot_v_d[i]) begin
          slot_v_d[i] = 1'b1;
          slot_l_d[i] = long_evt[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Slot, pointer, overflow and output registers.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      slot_v_q <= '0;
      slot_l_q <= '0;
      ovf_q    <= '0;
      ptr_q    <= '0;
      out_v_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      slot_v_q <= slot_v_d;
      slot_l_q <= slot_l_d;
      ovf_q    <= ovf_d;
      ptr_q    <= ptr_d;
      out_v_q  <= out_v_d;
      out_q    <= out_d;
    end
  end

  // Upper id bits exist only because the record is sized for the widest case.
  logic unused_id_bits;
  assign unused_id_bits = ^out_q.id;

  assign evt_valid = out_v_q;
  assign evt_id    = out_q.id[ID_W-1:0];
  assign evt_long  = out_q.is_long;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter at a scaled-down clock (100 clk per tick).
module tb_btn_event_arbiter;

  localparam int N_BTN = 5;

  logic             clk_100Mhz = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn;
  logic             evt_valid;
  logic             evt_ready;
  logic [2:0]       evt_id;
  logic             evt_long;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] ovf;
  logic             ovf_clr;

  btn_event_arbiter #(
    .N_BTN       (N_BTN),
    .CLK_HZ      (100_000),
    .SAMPLE_HZ   (1_000),
    .DEB_SAMPLES (8),
    .LONG_MS     (50)
  ) dut (
    .clk_100Mhz (clk_100Mhz),
    .rst        (rst),
    .btn        (btn),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .evt_long   (evt_long),
    .btn_level  (btn_level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  typedef struct { int id; int lng; int t; } rec_t;
  rec_t q[$];

  always @(posedge clk_100Mhz) cyc <= cyc + 1;

  // Record every handshake; sampled on the falling edge before it takes effect.
  always @(negedge clk_100Mhz)
    if (!rst && evt_valid && evt_ready)
      q.push_back('{int'(evt_id), int'(evt_long), cyc});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk_100Mhz);
    #1;
  endtask

  task automatic ticks(input int n);
    clks(n * 100);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clks(10);
    rst = 1'b0;
  endtask

  task automatic press(input int b, input int hold_ticks);
    btn[b] = 1'b1;
    ticks(hold_ticks);
    btn[b] = 1'b0;
    ticks(12);
  endtask

  initial begin
    rst = 1'b1; btn = '0; evt_ready = 1'b1; ovf_clr = 1'b0;
    clks(3);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id",    32'(evt_id),    0);
    chk("rst_long",  32'(evt_long),  0);
    chk("rst_level", 32'(btn_level), 0);
    chk("rst_ovf",   32'(ovf),       0);
    rst = 1'b0;

    // Bouncing contact, then a clean 20 ms hold: one short event.
    for (int k = 0; k < 10; k++) begin
      btn[0] = ~btn[0];
      clks(300);
    end
    chk("bounce_level", 32'(btn_level[0]), 0);
    btn[0] = 1'b1;
    ticks(20);
    chk("t1_level_hi", 32'(btn_level[0]), 1);
    btn[0] = 1'b0;
    ticks(15);
    chk("t1_level_lo", 32'(btn_level[0]), 0);
    chk("t1_count", q.size(), 1);
    if (q.size() == 1) begin
      chk("t1_id",   q[0].id,  0);
      chk("t1_long", q[0].lng, 0);
    end
    q.delete();

    // 120 ms hold: long event near tick 58, nothing on release.
    btn[1] = 1'b1;
    ticks(55);
    chk("t2_early", q.size(), 0);
    ticks(6);
    chk("t2_count", q.size(), 1);
    if (q.size() == 1) begin
      chk("t2_id",   q[0].id,  1);
      chk("t2_long", q[0].lng, 1);
    end
    ticks(59);
    btn[1] = 1'b0;
    ticks(15);
    chk("t2_release", q.size(), 1);
    chk("t2_level", 32'(btn_level[1]), 0);
    q.delete();

    // Simultaneous presses served in order on consecutive clocks, then wrap.
    do_reset();
    btn = 5'b01101;
    ticks(15);
    chk("t3_level", 32'(btn_level), 32'b01101);
    btn = '0;
    ticks(15);
    chk("t3_count", q.size(), 3);
    if (q.size() == 3) begin
      chk("t3_id0", q[0].id, 0);
      chk("t3_id1", q[1].id, 2);
      chk("t3_id2", q[2].id, 3);
      chk("t3_gap0", q[1].t - q[0].t, 1);
      chk("t3_gap1", q[2].t - q[1].t, 1);
    end
    q.delete();
    btn = 5'b10001;
    ticks(15);
    btn = '0;
    ticks(15);
    chk("t3w_count", q.size(), 2);
    if (q.size() == 2) begin
      chk("t3w_id0", q[0].id, 4);
      chk("t3w_id1", q[1].id, 0);
    end
    q.delete();

    // Back-pressure: output holds, slot fills, third press overflows.
    evt_ready = 1'b0;
    press(1, 15);
    chk("t4_valid", 32'(evt_valid), 1);
    chk("t4_id",    32'(evt_id),    1);
    chk("t4_long",  32'(evt_long),  0);
    press(1, 15);
    chk("t4_hold_valid", 32'(evt_valid), 1);
    chk("t4_hold_id",    32'(evt_id),    1);
    chk("t4_no_ovf",     32'(ovf),       0);
    press(1, 15);
    chk("t4_ovf", 32'(ovf), 32'b00010);
    chk("t4_none", q.size(), 0);
    evt_ready = 1'b1;
    clks(5);
    chk("t4_count", q.size(), 2);
    if (q.size() == 2) begin
      chk("t4_id0", q[0].id, 1);
      chk("t4_id1", q[1].id, 1);
    end
    chk("t4_idle", 32'(evt_valid), 0);
    chk("t4_ovf_sticky", 32'(ovf), 32'b00010);
    ovf_clr = 1'b1;
    clks(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(ovf), 0);
    q.delete();

    // Glitch shorter than the debounce window is ignored.
    btn[4] = 1'b1;
    clks(500);
    btn[4] = 1'b0;
    ticks(20);
    chk("t5_level", 32'(btn_level[4]), 0);
    chk("t5_count", q.size(), 0);

    // Reset mid-press discards it; the still-held button re-debounces.
    btn[2] = 1'b1;
    ticks(10);
    chk("t6_pre_level", 32'(btn_level[2]), 1);
    rst = 1'b1;
    clks(5);
    chk("t6_rst_valid", 32'(evt_valid), 0);
    chk("t6_rst_level", 32'(btn_level), 0);
    chk("t6_rst_ovf",   32'(ovf),       0);
    clks(5);
    rst = 1'b0;
    ticks(6);
    chk("t6_level_wait", 32'(btn_level[2]), 0);
    ticks(4);
    chk("t6_level_up", 32'(btn_level[2]), 1);
    ticks(10);
    btn[2] = 1'b0;
    ticks(15);
    chk("t6_count", q.size(), 1);
    if (q.size() == 1) begin
      chk("t6_id",   q[0].id,  2);
      chk("t6_long", q[0].lng, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
